axi4_read_responder: RTL and testbench

- AXI4 slave-side read responder for the byte-access verification bench.
- Accepts AR requests and returns R bursts whose data is a deterministic per-byte address pattern, so the bench can check byte lanes without a memory model.
- Built-in LFSR back-pressure exercises the master's AR hold rules.
- R-channel bubbles exercise the master's acceptance logic; R payload is always held stable while r_ready is low, as the protocol monitor requires.

---
 rtl/axi4_read_responder_pkg.sv | 30 +++
 rtl/axi4_read_responder_addr_gen.sv | 53 +++++
 rtl/axi4_read_responder.sv | 167 ++++++++++++++++
 tb/tb_axi4_read_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_read_responder_pkg.sv
// Shared definitions for the AXI4 read responder: default widths, burst
// encodings, response codes and FSM states.
package axi4_read_responder_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 8;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Lane index width; a single-lane bus still needs a 1-bit index.
    function automatic int lane_w(input int strb);
        return (strb > 1) ? $clog2(strb) : 1;
    endfunction

endpackage

// File: rtl/axi4_read_responder_addr_gen.sv
// Combinational burst address step, active byte-lane window and error
// detection for the beat currently being presented.
module axi_burst_addr_gen
    import axi4_read_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    localparam int STRB      = DATA_WIDTH / 8,
    localparam int LANE_W    = lane_w(DATA_WIDTH / 8)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  burst_e                burst,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [LANE_W-1:0]     lane_lo,
    output logic [LANE_W-1:0]     lane_hi,
    output logic                  err
);

    localparam int LOG2_STRB = $clog2(STRB);

    logic [ADDR_WIDTH-1:0] beat_bytes;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] strb_mask;

    always_comb begin
        beat_bytes = ADDR_WIDTH'(1) << size;
        size_mask  = beat_bytes - ADDR_WIDTH'(1);
        aligned    = addr & ~size_mask;
        wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        strb_mask  = ADDR_WIDTH'(STRB - 1);

        lane_lo = LANE_W'(addr & strb_mask);
        lane_hi = LANE_W'((aligned | size_mask) & strb_mask);

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = aligned + beat_bytes;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + beat_bytes) & wrap_mask);
            default:     next_addr = addr;
        endcase

        // An aligned WRAP start stays aligned, so checking the live beat address is enough.
        err = (burst == BURST_RSVD)
            || (size > 3'(LOG2_STRB))
            || ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            || ((burst == BURST_WRAP) && ((addr & size_mask) != '0));
    end

endmodule

// File: rtl/axi4_read_responder.sv
// AXI4 read responder returning a per-byte address pattern, with LFSR-driven
// AR back-pressure and R-channel bubbles.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no burst in flight; ar_ready follows the stall LFSR
//   ST_RESP | returning beats of the latched burst; ar_ready held low
module axi4_read_responder
    import axi4_read_responder_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = AXI_ADDR_W,
    parameter int          AXI_DATA_WIDTH = AXI_DATA_W,
    parameter int          AXI_ID_WIDTH   = AXI_ID_W,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter bit          AR_STALL_EN    = 1'b1,
    parameter bit          R_BUBBLE_EN    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    input  logic [1:0]                axi_ar_burst,
    input  logic [2:0]                axi_ar_size,
    input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    input  logic [7:0]                axi_ar_len,
    input  logic                      axi_ar_valid,
    output logic                      axi_ar_ready,
    output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    output logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    output logic [1:0]                axi_r_resp,
    output logic                      axi_r_last,
    output logic                      axi_r_valid,
    input  logic                      axi_r_ready
);

    localparam int          STRB      = AXI_DATA_WIDTH / 8;
    localparam int          LANE_W    = lane_w(STRB);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_e                    state_q, state_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic                      ar_ready_q, ar_ready_d;
    logic                      r_valid_q, r_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    burst_e                    burst_q, burst_d;
    logic [2:0]                size_q, size_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                beat_q, beat_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;

    logic [AXI_ADDR_WIDTH-1:0] next_addr;
    logic [LANE_W-1:0]         lane_lo;
    logic [LANE_W-1:0]         lane_hi;
    logic                      err;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      last_beat;
    logic                      bubble;
    logic [AXI_DATA_WIDTH-1:0] beat_data;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .burst     (burst_q),
        .size      (size_q),
        .len       (len_q),
        .next_addr (next_addr),
        .lane_lo   (lane_lo),
        .lane_hi   (lane_hi),
        .err       (err)
    );

    assign ar_hs     = axi_ar_valid & ar_ready_q;
    assign r_hs      = r_valid_q & axi_r_ready;
    assign last_beat = (beat_q == len_q);
    assign bubble    = R_BUBBLE_EN & lfsr_q[1];

    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        state_d   = state_q;
        r_valid_d = r_valid_q;
        addr_d    = addr_q;
        burst_d   = burst_q;
        size_d    = size_q;
        len_d     = len_q;
        beat_d    = beat_q;
        id_d      = id_q;

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    addr_d    = axi_ar_addr;
                    burst_d   = burst_e'(axi_ar_burst);
                    size_d    = axi_ar_size;
                    len_d     = axi_ar_len;
                    id_d      = axi_ar_id;
                    beat_d    = 8'd0;
                    state_d   = ST_RESP;
                    r_valid_d = ~bubble;
                end
            end
            ST_RESP: begin
                if (r_hs) begin
                    if (last_beat) begin
                        state_d   = ST_IDLE;
                        r_valid_d = 1'b0;
                    end else begin
                        addr_d    = next_addr;
                        beat_d    = beat_q + 8'd1;
                        r_valid_d = ~bubble;
                    end
                end else if (!r_valid_q) begin
                    r_valid_d = ~bubble;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered from next-cycle state/LFSR so ar_ready is a clean flop output.
        ar_ready_d = (state_d == ST_IDLE) & ~(AR_STALL_EN & lfsr_d[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= LFSR_SEED;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            addr_q     <= '0;
            burst_q    <= BURST_FIXED;
            size_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            size_q     <= size_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            id_q       <= id_d;
        end
    end

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < STRB; k++) begin
            if (k >= int'(lane_lo) && k <= int'(lane_hi)) begin
                beat_data[k*8 +: 8] = 8'((addr_q & ~AXI_ADDR_WIDTH'(STRB - 1)) + AXI_ADDR_WIDTH'(k));
            end
        end
    end

    // Payload only changes on a handshake, so gating with r_valid keeps it stable and zero in reset.
    assign axi_ar_ready = ar_ready_q;
    assign axi_r_valid  = r_valid_q;
    assign axi_r_data   = (r_valid_q && !err) ? beat_data : '0;
    assign axi_r_resp   = (r_valid_q && err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_r_last   = r_valid_q & last_beat;
    assign axi_r_id     = r_valid_q ? id_q : '0;

endmodule

// File: tb/tb_axi4_read_responder.sv
// Scoreboard bench: instance 0 runs without stalls/bubbles for directed
// vectors, instance 1 runs with both enabled for random bursts and reset.
`timescale 1ns/1ps
module tb_axi4_read_responder;
    import axi4_read_responder_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0][31:0] ar_addr;
    logic [1:0][1:0]  ar_burst;
    logic [1:0][2:0]  ar_size;
    logic [1:0][7:0]  ar_id;
    logic [1:0][7:0]  ar_len;
    logic [1:0]       ar_valid;
    logic [1:0]       ar_ready;
    logic [1:0][31:0] r_data;
    logic [1:0][7:0]  r_id;
    logic [1:0][1:0]  r_resp;
    logic [1:0]       r_last;
    logic [1:0]       r_valid;
    logic [1:0]       r_ready;

    int    checks = 0;
    int    failures = 0;
    beat_t q0[$];
    beat_t q1[$];
    int    issued[2];
    int    done_cnt[2];
    int    rr_mode[2];
    int    stall_cnt[2];
    logic  held[2];
    beat_t held_beat[2];

    always #5 clk = ~clk;

    axi4_read_responder #(
        .AXI_ADDR_WIDTH (32), .AXI_DATA_WIDTH (32), .AXI_ID_WIDTH (8),
        .LFSR_SEED (16'hACE1), .AR_STALL_EN (1'b0), .R_BUBBLE_EN (1'b0)
    ) u_dut0 (
        .clk (clk), .rst_n (rst_n),
        .axi_ar_addr (ar_addr[0]), .axi_ar_burst (ar_burst[0]), .axi_ar_size (ar_size[0]),
        .axi_ar_id (ar_id[0]), .axi_ar_len (ar_len[0]), .axi_ar_valid (ar_valid[0]),
        .axi_ar_ready (ar_ready[0]), .axi_r_data (r_data[0]), .axi_r_id (r_id[0]),
        .axi_r_resp (r_resp[0]), .axi_r_last (r_last[0]), .axi_r_valid (r_valid[0]),
        .axi_r_ready (r_ready[0])
    );

    axi4_read_responder #(
        .AXI_ADDR_WIDTH (32), .AXI_DATA_WIDTH (32), .AXI_ID_WIDTH (8),
        .LFSR_SEED (16'hACE1), .AR_STALL_EN (1'b1), .R_BUBBLE_EN (1'b1)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n),
        .axi_ar_addr (ar_addr[1]), .axi_ar_burst (ar_burst[1]), .axi_ar_size (ar_size[1]),
        .axi_ar_id (ar_id[1]), .axi_ar_len (ar_len[1]), .axi_ar_valid (ar_valid[1]),
        .axi_ar_ready (ar_ready[1]), .axi_r_data (r_data[1]), .axi_r_id (r_id[1]),
        .axi_r_resp (r_resp[1]), .axi_r_last (r_last[1]), .axi_r_valid (r_valid[1]),
        .axi_r_ready (r_ready[1])
    );

    task automatic check(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h required=0x%0h t=%0t", name, u, act, exp, $time);
        end
    endtask

    task automatic push(input int u, input logic [31:0] d, input logic [7:0] id,
                        input logic [1:0] resp, input logic last);
        beat_t b;
        b = '{data: d, id: id, resp: resp, last: last};
        if (u == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    // Monitor: pops the scoreboard on every R handshake and polices the hold rule.
    task automatic mon_step(input int u);
        beat_t act;
        beat_t exp;
        int    qsz;
        if (!rst_n) begin
            held[u] = 1'b0;
            done_cnt[u] = issued[u];
            if (u == 0) q0.delete();
            else q1.delete();
            return;
        end
        act = '{data: r_data[u], id: r_id[u], resp: r_resp[u], last: r_last[u]};
        if (issued[u] != done_cnt[u]) check("ar_ready_in_burst", u, 64'(ar_ready[u]), 64'd0);
        if (held[u]) begin
            check("hold_valid", u, 64'(r_valid[u]), 64'd1);
            check("hold_payload", u, 64'(act), 64'(held_beat[u]));
        end
        held[u] = 1'b0;
        if (r_valid[u]) begin
            if (r_ready[u]) begin
                qsz = (u == 0) ? q0.size() : q1.size();
                checks++;
                if (qsz == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat dut%0d actual=0x%0h required=none", u, act);
                end else begin
                    exp = (u == 0) ? q0.pop_front() : q1.pop_front();
                    checks--;
                    check("beat", u, 64'(act), 64'(exp));
                    if (exp.last) done_cnt[u]++;
                end
            end else begin
                held[u] = 1'b1;
                held_beat[u] = act;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon_step(u);
    end

    // r_ready driver: 0 always ready, 1 random, 2 low for three cycles per beat.
    always @(posedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            case (rr_mode[u])
                0: r_ready[u] = 1'b1;
                1: r_ready[u] = ($urandom_range(0, 3) != 0);
                default: begin
                    if (r_valid[u] && stall_cnt[u] < 3) begin
                        r_ready[u] = 1'b0;
                        stall_cnt[u]++;
                    end else if (r_valid[u]) begin
                        r_ready[u] = 1'b1;
                        stall_cnt[u] = 0;
                    end else begin
                        r_ready[u] = 1'b0;
                        stall_cnt[u] = 0;
                    end
                end
            endcase
        end
    end

    task automatic send_ar(input int u, input logic [31:0] a, input logic [1:0] b, input logic [2:0] s,
                           input logic [7:0] l, input logic [7:0] id, input bit chk_lat);
        bit done;
        done = 1'b0;
        ar_addr[u] = a; ar_burst[u] = b; ar_size[u] = s; ar_len[u] = l; ar_id[u] = id;
        ar_valid[u] = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ar_ready[u]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        ar_valid[u] = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ar_timeout dut%0d actual=no_ar_ready required=ar_ready", u);
        end else begin
            issued[u]++;
            if (chk_lat) begin
                @(negedge clk);
                check("first_r_latency", u, 64'(r_valid[u]), 64'd1);
            end
        end
    endtask

    task automatic wait_done(input int u);
        int n;
        n = 0;
        while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL drain_timeout dut%0d actual=%0d_left required=0", u,
                     (u == 0) ? q0.size() : q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [1:0] b,
                                               input int s, input int l, input int i);
        logic [31:0] nb, cont, lower;
        nb = 32'd1 << s;
        if (b == 2'd1) return (i == 0) ? a : (a & ~(nb - 32'd1)) + nb * 32'(i);
        cont  = nb * 32'(l + 1);
        lower = a & ~(cont - 32'd1);
        return lower + ((a - lower + nb * 32'(i)) % cont);
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] a, input int s);
        logic [31:0] d, nb, base, ba;
        d    = '0;
        nb   = 32'd1 << s;
        base = a & ~(nb - 32'd1);
        for (int i = 0; i < int'(nb); i++) begin
            ba = base + 32'(i);
            if (ba >= a) d[int'(ba[1:0])*8 +: 8] = ba[7:0];
        end
        return d;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog dut- actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  b;
        int          s, l, n;

        ar_addr = '0; ar_burst = '0; ar_size = '0; ar_id = '0; ar_len = '0;
        ar_valid = '0; r_ready = '0;
        for (int u = 0; u < 2; u++) begin
            issued[u] = 0; done_cnt[u] = 0; rr_mode[u] = 0; stall_cnt[u] = 0; held[u] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_ar_ready", u, 64'(ar_ready[u]), 64'd0);
            check("rst_r_valid", u, 64'(r_valid[u]), 64'd0);
            check("rst_r_last", u, 64'(r_last[u]), 64'd0);
            check("rst_r_data", u, 64'(r_data[u]), 64'd0);
        end
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ar_ready", 0, 64'(ar_ready[0]), 64'd1);

        // INCR aligned, word beats
        push(0, 32'h03020100, 8'd5, RESP_OKAY, 1'b0);
        push(0, 32'h07060504, 8'd5, RESP_OKAY, 1'b0);
        push(0, 32'h0B0A0908, 8'd5, RESP_OKAY, 1'b0);
        push(0, 32'h0F0E0D0C, 8'd5, RESP_OKAY, 1'b1);
        send_ar(0, 32'h100, 2'd1, 3'd2, 8'd3, 8'd5, 1'b1);
        wait_done(0);

        // INCR unaligned byte beats
        push(0, 32'h00000100, 8'd7, RESP_OKAY, 1'b0);
        push(0, 32'h00020000, 8'd7, RESP_OKAY, 1'b0);
        push(0, 32'h03000000, 8'd7, RESP_OKAY, 1'b1);
        send_ar(0, 32'h101, 2'd1, 3'd0, 8'd2, 8'd7, 1'b0);
        wait_done(0);

        // WRAP across the 16-byte container
        push(0, 32'h1B1A1918, 8'd9, RESP_OKAY, 1'b0);
        push(0, 32'h1F1E1D1C, 8'd9, RESP_OKAY, 1'b0);
        push(0, 32'h13121110, 8'd9, RESP_OKAY, 1'b0);
        push(0, 32'h17161514, 8'd9, RESP_OKAY, 1'b1);
        send_ar(0, 32'h18, 2'd2, 3'd2, 8'd3, 8'd9, 1'b0);
        wait_done(0);

        // FIXED halfword with r_ready stalls
        rr_mode[0] = 2;
        push(0, 32'h23220000, 8'd3, RESP_OKAY, 1'b0);
        push(0, 32'h23220000, 8'd3, RESP_OKAY, 1'b1);
        send_ar(0, 32'h22, 2'd0, 3'd1, 8'd1, 8'd3, 1'b0);
        wait_done(0);
        rr_mode[0] = 0;

        // Error bursts: reserved type, bad WRAP length, unaligned WRAP, oversize beat
        for (int i = 0; i < 3; i++) push(0, 32'h0, 8'h44, RESP_SLVERR, i == 2);
        send_ar(0, 32'h40, 2'd3, 3'd2, 8'd2, 8'h44, 1'b0);
        wait_done(0);
        for (int i = 0; i < 3; i++) push(0, 32'h0, 8'h45, RESP_SLVERR, i == 2);
        send_ar(0, 32'h0, 2'd2, 3'd2, 8'd2, 8'h45, 1'b0);
        wait_done(0);
        for (int i = 0; i < 4; i++) push(0, 32'h0, 8'h46, RESP_SLVERR, i == 3);
        send_ar(0, 32'h1A, 2'd2, 3'd2, 8'd3, 8'h46, 1'b0);
        wait_done(0);
        push(0, 32'h0, 8'h47, RESP_SLVERR, 1'b1);
        send_ar(0, 32'h80, 2'd1, 3'd3, 8'd0, 8'h47, 1'b0);
        wait_done(0);

        // Random INCR/WRAP bursts with stalls, bubbles and random r_ready
        rr_mode[1] = 1;
        for (int t = 0; t < 200; t++) begin
            a = $urandom();
            s = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) begin
                b = 2'd1;
                l = $urandom_range(0, 15);
            end else begin
                b = 2'd2;
                l = (2 << $urandom_range(0, 3)) - 1;
                a = a & ~((32'd1 << s) - 32'd1);
            end
            for (int i = 0; i <= l; i++)
                push(1, model_data(model_addr(a, b, s, l, i), s), 8'(t), RESP_OKAY, i == l);
            send_ar(1, a, b, 3'(s), 8'(l), 8'(t), 1'b0);
            wait_done(1);
        end

        // Reset in the middle of a burst
        for (int i = 0; i < 8; i++)
            push(1, model_data(model_addr(32'h300, 2'd1, 2, 7, i), 2), 8'hAA, RESP_OKAY, i == 7);
        send_ar(1, 32'h300, 2'd1, 3'd2, 8'd7, 8'hAA, 1'b0);
        n = 0;
        while (q1.size() > 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("mid_burst_progress", 1, 64'(n < 500), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ar_ready", 1, 64'(ar_ready[1]), 64'd0);
        check("async_rst_r_valid", 1, 64'(r_valid[1]), 64'd0);
        check("async_rst_r_last", 1, 64'(r_last[1]), 64'd0);
        check("async_rst_r_data", 1, 64'(r_data[1]), 64'd0);
        check("async_rst_r_id", 1, 64'(r_id[1]), 64'd0);
        check("async_rst_r_resp", 1, 64'(r_resp[1]), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(1, 32'h03020100, 8'h5A, RESP_OKAY, 1'b0);
        push(1, 32'h07060504, 8'h5A, RESP_OKAY, 1'b1);
        send_ar(1, 32'h200, 2'd1, 3'd2, 8'd1, 8'h5A, 1'b0);
        wait_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
